// File: rtl/endian_swapper_pipe.sv
// Avalon-ST byte-order swapper with per-packet mode latch, 2-entry skid buffer
// and a small Avalon-MM CSR block (control, packet/beat counters, sticky errors).
module endian_swapper_pipe #(
   parameter  int DATA_BYTES = 8,
   localparam int EMPTY_W    = $clog2(DATA_BYTES)
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [DATA_BYTES*8-1:0] stream_in_data,
   input  logic [EMPTY_W-1:0]      stream_in_empty,
   input  logic                    stream_in_valid,
   input  logic                    stream_in_startofpacket,
   input  logic                    stream_in_endofpacket,
   output logic                    stream_in_ready,
   output logic [DATA_BYTES*8-1:0] stream_out_data,
   output logic [EMPTY_W-1:0]      stream_out_empty,
   output logic                    stream_out_valid,
   output logic                    stream_out_startofpacket,
   output logic                    stream_out_endofpacket,
   input  logic                    stream_out_ready,
   input  logic [1:0]              csr_address,
   input  logic                    csr_read,
   input  logic                    csr_write,
   input  logic [31:0]             csr_writedata,
   output logic [31:0]             csr_readdata,
   output logic                    csr_readdatavalid,
   output logic                    csr_waitrequest
);
   localparam int W = DATA_BYTES * 8;

   typedef struct packed {
      logic [W-1:0]       data;
      logic [EMPTY_W-1:0] empty;
      logic               sop;
      logic               eop;
   } beat_t;

   // Lane sizes smaller than the beat are clamped to the whole beat.
   function automatic logic [W-1:0] swap_bytes(input logic [W-1:0] d, input logic [1:0] m);
      int lane;
      logic [W-1:0] r;
      case (m)
         2'd1:    lane = (DATA_BYTES < 2) ? DATA_BYTES : 2;
         2'd2:    lane = (DATA_BYTES < 4) ? DATA_BYTES : 4;
         2'd3:    lane = DATA_BYTES;
         default: lane = 1;
      endcase
      r = '0;
      for (int i = 0; i < DATA_BYTES; i++)
         r[i*8 +: 8] = d[((i / lane) * lane + lane - 1 - (i % lane)) * 8 +: 8];
      return r;
   endfunction

   logic        in_rdy, out_vld, skid_vld;
   beat_t       in_beat, out_beat, skid_beat;
   logic [1:0]  csr_mode, active_mode, beat_mode;
   logic        in_packet;
   logic [31:0] packet_count, beat_count, rd_mux;
   logic [2:1]  status;
   logic        in_fire, out_load, sop_err, orphan_err, csr_wr, w1c_hit;
   logic        unused_wd;

   assign unused_wd  = &{1'b0, csr_writedata[31:3]};
   assign in_fire    = stream_in_valid & in_rdy;
   assign out_load   = ~out_vld | stream_out_ready;
   assign beat_mode  = stream_in_startofpacket ? csr_mode : active_mode;
   assign in_beat    = '{data:  swap_bytes(stream_in_data, beat_mode),
                         empty: stream_in_empty,
                         sop:   stream_in_startofpacket,
                         eop:   stream_in_endofpacket};
   assign sop_err    = in_fire & stream_in_startofpacket & in_packet;
   assign orphan_err = in_fire & ~stream_in_startofpacket & ~in_packet;
   assign csr_wr     = csr_write & ~csr_read;
   assign w1c_hit    = csr_wr & (csr_address == 2'd3);

   // ready is only dropped while the skid entry holds a beat
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         in_rdy    <= 1'b0;
         out_vld   <= 1'b0;
         skid_vld  <= 1'b0;
         out_beat  <= '0;
         skid_beat <= '0;
      end else if (out_load) begin
         in_rdy <= 1'b1;
         if (skid_vld) begin
            out_beat <= skid_beat;
            out_vld  <= 1'b1;
            skid_vld <= 1'b0;
         end else if (in_fire) begin
            out_beat <= in_beat;
            out_vld  <= 1'b1;
         end else begin
            out_vld <= 1'b0;
         end
      end else if (in_fire) begin
         skid_beat <= in_beat;
         skid_vld  <= 1'b1;
         in_rdy    <= 1'b0;
      end else begin
         in_rdy <= ~skid_vld;
      end
   end

   always_comb begin
      rd_mux = '0;
      case (csr_address)
         2'd0: rd_mux = {30'b0, csr_mode};
         2'd1: rd_mux = packet_count;
         2'd2: rd_mux = beat_count;
         2'd3: rd_mux = {29'b0, status, in_packet};
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         csr_mode          <= 2'd0;
         active_mode       <= 2'd0;
         in_packet         <= 1'b0;
         packet_count      <= '0;
         beat_count        <= '0;
         status            <= '0;
         csr_readdata      <= '0;
         csr_readdatavalid <= 1'b0;
      end else begin
         if (csr_wr && csr_address == 2'd0)
            csr_mode <= csr_writedata[1:0];
         if (in_fire && stream_in_startofpacket)
            active_mode <= csr_mode;
         if (in_fire)
            in_packet <= ~stream_in_endofpacket & (stream_in_startofpacket | in_packet);
         packet_count <= packet_count + {31'b0, in_fire & stream_in_startofpacket};
         beat_count   <= beat_count + {31'b0, in_fire};
         // a new error event in the same cycle as a W1C clear keeps its bit set
         status <= (status & ~(w1c_hit ? csr_writedata[2:1] : 2'b00)) | {orphan_err, sop_err};
         csr_readdatavalid <= csr_read;
         csr_readdata      <= csr_read ? rd_mux : 32'd0;
      end
   end

   assign stream_in_ready          = in_rdy;
   assign stream_out_valid         = out_vld;
   assign stream_out_data          = out_beat.data;
   assign stream_out_empty         = out_beat.empty;
   assign stream_out_startofpacket = out_beat.sop;
   assign stream_out_endofpacket   = out_beat.eop;
   assign csr_waitrequest          = ~reset_n;
endmodule

// File: doc/endian_swapper_pipe.md
Name: endian_swapper_pipe

Overview:
Parametrised next-generation Avalon-ST endian swapper.
- Sits inline on an Avalon-ST datapath (readyLatency 0).
- Reorders bytes within each beat at a CSR-selected granularity: none, 16-bit, 32-bit or full beat.
- Registered 2-entry skid buffer gives full throughput with registered ready. The swap mode is latched per packet at SOP, so CSR writes never stall.
- Avalon-MM CSR slave (readLatency 1) exposes control, packet/beat counters and sticky protocol-error status.

Parameters:
DATA_BYTES, 8, beat width in bytes; power of two, 2..64.
EMPTY_W, $clog2(DATA_BYTES), width of empty fields (derived, not overridden).

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
stream_in_data  in  DATA_BYTES*8  input beat
stream_in_empty  in  EMPTY_W  invalid bytes in EOP beat
stream_in_valid  in  1  input valid
stream_in_startofpacket  in  1  SOP
stream_in_endofpacket  in  1  EOP
stream_in_ready  out  1  input ready (registered)
stream_out_data  out  DATA_BYTES*8  swapped beat
stream_out_empty  out  EMPTY_W  passed through unchanged
stream_out_valid  out  1  output valid
stream_out_startofpacket  out  1  SOP
stream_out_endofpacket  out  1  EOP
stream_out_ready  in  1  downstream ready
csr_address  in  2  word address
csr_read  in  1  read strobe
csr_write  in  1  write strobe
csr_writedata  in  32  write data
csr_readdata  out  32  read data
csr_readdatavalid  out  1  read data valid
csr_waitrequest  out  1  high only while reset_n low

Behaviour:
- Reset (async assert, sync-safe release): all stream_out_* = 0, stream_in_ready = 0, csr_readdata = 0, csr_readdatavalid = 0, mode = 0, counters = 0, status = 0, skid empty.
- First cycle after reset: stream_in_ready = 1.
- Transfer rules:
  - Input accepted when stream_in_valid & stream_in_ready.
  - Output accepted when stream_out_valid & stream_out_ready.
- Skid buffer:
  - Two entries: output register + skid register.
  - stream_in_ready = !(skid occupied), registered.
  - Latency 1 cycle, input acceptance to stream_out_valid.
  - Throughput 1 beat/cycle under continuous ready.
  - Output stays stable while valid & !ready.
  - No beat is dropped or duplicated under any ready pattern.
- Swap modes (CSR0[1:0]):
  - 0: passthrough.
  - 1: reverse bytes within each 16-bit lane.
  - 2: reverse bytes within each 32-bit lane.
  - 3: reverse all DATA_BYTES bytes.
  - If DATA_BYTES < lane size, the lane is clamped to the full beat (DATA_BYTES=2: mode 2 = mode 3).
  - Swap applied at input acceptance.
- Mode latching:
  - active_mode is loaded from CSR0 on every accepted SOP beat and held until the next accepted SOP.
  - A CSR write mid-packet affects only the next packet.
  - Same-cycle CSR write and SOP acceptance: the SOP uses the old value.
- empty, SOP and EOP travel with their beat unchanged.
- Packet tracking:
  - in_packet is set on accepted SOP and cleared on accepted EOP.
  - SOP&EOP on one beat: in_packet stays 0.
- Counters (32-bit, wrap 0xFFFFFFFF -> 0):
  - packet_count increments on each accepted SOP.
  - beat_count increments on each accepted beat.
- Protocol errors (status sticky bits):
  - Bit1, sop_err: accepted SOP while in_packet. The new packet starts normally and packet_count increments.
  - Bit2, orphan_err: accepted non-SOP beat while !in_packet. The beat is forwarded using the current active_mode.
- CSR map:
  - 0: R/W, bits[1:0] mode, other bits read 0.
  - 1: RO, packet_count.
  - 2: RO, beat_count.
  - 3: status. Bit0 = in_packet (RO); bits 2:1 are W1C; other bits 0.
- CSR timing:
  - Read: csr_readdatavalid pulses exactly one cycle after csr_read, carrying the value at the read cycle.
  - Writes to RO registers are ignored.
  - csr_read & csr_write in the same cycle: the read is performed and the write is dropped.
  - W1C clear coinciding with a new error event: set wins.
- Reset asserted mid-packet: all state clears immediately; the partial packet is lost; no output beat after release until new input.

Test Plan:
- DATA_BYTES=8, mode 3, single beat 0x0011223344556677 SOP&EOP, ready=1 -> out 0x7766554433221100 one cycle later; CSR1=1, CSR2=1.
- Mode 1 then mode 2 on 0x0011223344556677 -> 0x1100332255447766 and 0x3322110077665544 respectively.
- 3-beat packet with random stream_out_ready (50%) -> data/empty/SOP/EOP order identical; no loss/dup; stable output while stalled; 1 beat/cycle when ready=1.
- Write CSR0=3 after beat 1 of a mode-0 packet -> remaining beats passthrough; next packet swapped; waitrequest stays 0.
- SOP with no intervening EOP, then a non-SOP beat after EOP -> CSR3 reads 0x6 (bits 2:1 set); write 0x6 -> reads 0x0.
- Preload beat_count near wrap via 0xFFFFFFFF accepted beats (forced), one more beat -> CSR2=0; reset_n pulse mid-packet -> all CSRs 0, stream_out_valid 0.
